// File: rtl/lemon_pkg.sv
// Shared types, opcode constants and select encodings for the LemonPC
// multi-cycle control unit.
package lemon_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_DOUBLE = 3'b011;
    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0100000;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_PASS_B = 4'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    // Everything the datapath needs from one decoded instruction.
    typedef struct packed {
        logic [2:0] imm_sel;
        logic [3:0] alu_op;
        logic       src_a_sel;
        logic       src_b_sel;
        logic [1:0] wb_sel;
        logic       pc_sel;
        logic       is_load;
        logic       is_store;
        logic [2:0] mem_size;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/lemon_decode.sv
// Combinational instruction decoder: maps one 32-bit word to a control bundle
// plus legal/ebreak indications. XLEN decides whether ld/sd are accepted.
module lemon_decode
    import lemon_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0] inst,
    output ctrl_t       ctrl,
    output logic        legal,
    output logic        is_ebreak
);

    localparam bit WIDE = (XLEN == 64);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       mem_width_ok;

    assign opcode       = inst[6:0];
    assign funct3       = inst[14:12];
    assign funct7       = inst[31:25];
    assign mem_width_ok = (funct3 == F3_WORD) || (WIDE && (funct3 == F3_DOUBLE));

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        ctrl      = CTRL_NOP;
        legal     = 1'b0;
        is_ebreak = (inst == EBREAK);

        case (opcode)
            OP_IMM: begin
                if (funct3 == F3_ADD) begin
                    legal          = 1'b1;
                    ctrl.imm_sel   = IMM_I;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.src_b_sel = 1'b1;
                    ctrl.wb_sel    = WB_ALU;
                end
            end
            OP_REG: begin
                if (funct3 == F3_ADD && (funct7 == F7_ADD || funct7 == F7_SUB)) begin
                    legal       = 1'b1;
                    ctrl.alu_op = (funct7 == F7_SUB) ? ALU_SUB : ALU_ADD;
                    ctrl.wb_sel = WB_ALU;
                end
            end
            OP_LUI: begin
                legal          = 1'b1;
                ctrl.imm_sel   = IMM_U;
                ctrl.alu_op    = ALU_PASS_B;
                ctrl.src_b_sel = 1'b1;
                ctrl.wb_sel    = WB_ALU;
            end
            OP_AUIPC: begin
                legal          = 1'b1;
                ctrl.imm_sel   = IMM_U;
                ctrl.alu_op    = ALU_ADD;
                ctrl.src_a_sel = 1'b1;
                ctrl.src_b_sel = 1'b1;
                ctrl.wb_sel    = WB_ALU;
            end
            OP_JAL: begin
                legal          = 1'b1;
                ctrl.imm_sel   = IMM_J;
                ctrl.alu_op    = ALU_ADD;
                ctrl.src_a_sel = 1'b1;
                ctrl.src_b_sel = 1'b1;
                ctrl.wb_sel    = WB_PC4;
                ctrl.pc_sel    = 1'b1;
            end
            OP_JALR: begin
                if (funct3 == F3_ADD) begin
                    legal          = 1'b1;
                    ctrl.imm_sel   = IMM_I;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.src_b_sel = 1'b1;
                    ctrl.wb_sel    = WB_PC4;
                    ctrl.pc_sel    = 1'b1;
                end
            end
            OP_LOAD: begin
                if (mem_width_ok) begin
                    legal          = 1'b1;
                    ctrl.imm_sel   = IMM_I;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.src_b_sel = 1'b1;
                    ctrl.wb_sel    = WB_LOAD;
                    ctrl.is_load   = 1'b1;
                    ctrl.mem_size  = funct3;
                end
            end
            OP_STORE: begin
                if (mem_width_ok) begin
                    legal          = 1'b1;
                    ctrl.imm_sel   = IMM_S;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.src_b_sel = 1'b1;
                    ctrl.is_store  = 1'b1;
                    ctrl.mem_size  = funct3;
                end
            end
            OP_SYSTEM: begin
                legal = is_ebreak;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/lemon_ctrl_fsm.sv
// LemonPC multi-cycle control unit: sequences IF/ID/EX/MEM/WB with stallable
// instruction and data memory handshakes and drives the datapath controls.
module lemon_ctrl_fsm
    import lemon_pkg::*;
#(
    parameter int XLEN            = 64,
    parameter int HALT_ON_ILLEGAL = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] inst,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [2:0]  dmem_size,
    input  logic        dmem_ack,
    output logic [2:0]  imm_sel,
    output logic [3:0]  alu_op,
    output logic        src_a_sel,
    output logic        src_b_sel,
    output logic [1:0]  wb_sel,
    output logic        wb_en,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        ir_we,
    output logic        ebreak_flag,
    output logic        illegal_flag,
    output logic        halted
);

    state_t      state_q, state_d;
    logic [31:0] ir_q;
    ctrl_t       ctrl_q, ctrl_d;
    logic        imem_req_q, imem_req_d;
    logic        dmem_req_q, dmem_req_d;
    logic        ebreak_q, illegal_q;
    logic        ebreak_set, illegal_set;
    logic        ir_load, wb_pulse, pc_pulse;

    ctrl_t       dec_ctrl;
    logic        dec_legal;
    logic        dec_ebreak;

    lemon_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .inst      (ir_q),
        .ctrl      (dec_ctrl),
        .legal     (dec_legal),
        .is_ebreak (dec_ebreak)
    );

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        imem_req_d  = 1'b0;
        dmem_req_d  = 1'b0;
        ir_load     = 1'b0;
        wb_pulse    = 1'b0;
        pc_pulse    = 1'b0;
        ebreak_set  = 1'b0;
        illegal_set = 1'b0;

        case (state_q)
            ST_IF: begin
                // An ack only counts while our own request is up.
                if (imem_req_q && imem_ack) begin
                    ir_load = 1'b1;
                    state_d = ST_ID;
                end else begin
                    imem_req_d = 1'b1;
                end
            end
            ST_ID: begin
                if (dec_ebreak) begin
                    ebreak_set = 1'b1;
                    state_d    = ST_HALT;
                end else if (!dec_legal) begin
                    illegal_set = 1'b1;
                    if (HALT_ON_ILLEGAL != 0) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_pulse   = 1'b1;
                        imem_req_d = 1'b1;
                        state_d    = ST_IF;
                    end
                end else begin
                    ctrl_d  = dec_ctrl;
                    state_d = ST_EX;
                end
            end
            ST_EX: begin
                if (ctrl_q.is_load || ctrl_q.is_store) begin
                    dmem_req_d = 1'b1;
                    state_d    = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_req_q && dmem_ack) begin
                    if (ctrl_q.is_store) begin
                        pc_pulse   = 1'b1;
                        imem_req_d = 1'b1;
                        ctrl_d     = CTRL_NOP;
                        state_d    = ST_IF;
                    end else begin
                        state_d = ST_WB;
                    end
                end else begin
                    dmem_req_d = 1'b1;
                end
            end
            ST_WB: begin
                wb_pulse   = 1'b1;
                pc_pulse   = 1'b1;
                imem_req_d = 1'b1;
                // Selects are cleared once the instruction retires so IF/ID
                // present pc_sel=0 for an illegal-NOP PC bump.
                ctrl_d     = CTRL_NOP;
                state_d    = ST_IF;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IF;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IF;
            ctrl_q     <= CTRL_NOP;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            ebreak_q   <= 1'b0;
            illegal_q  <= 1'b0;
            // NOTE: the instruction register is reset too, so decode never sees stale or X data.
            ir_q       <= '0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            ebreak_q   <= ebreak_q | ebreak_set;
            illegal_q  <= illegal_q | illegal_set;
            if (ir_load) begin
                ir_q <= inst;
            end
        end
    end

    // Strobes are qualified with rst so a reset coinciding with an ack pulses nothing.
    assign ir_we        = ir_load & ~rst;
    assign wb_en        = wb_pulse & ~rst;
    assign pc_we        = pc_pulse & ~rst;

    assign imem_req     = imem_req_q;
    assign dmem_req     = dmem_req_q;
    assign dmem_we      = ctrl_q.is_store;
    assign dmem_size    = ctrl_q.mem_size;
    assign imm_sel      = ctrl_q.imm_sel;
    assign alu_op       = ctrl_q.alu_op;
    assign src_a_sel    = ctrl_q.src_a_sel;
    assign src_b_sel    = ctrl_q.src_b_sel;
    assign wb_sel       = ctrl_q.wb_sel;
    assign pc_sel       = ctrl_q.pc_sel;
    assign ebreak_flag  = ebreak_q;
    assign illegal_flag = illegal_q;
    assign halted       = (state_q == ST_HALT);

endmodule
